// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared constants for the ID/EX stage of the 5-stage MIPS core:
//   control-bundle width and bit positions, forwarding-select encodings,
//   the NOP control word and the destination-register helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

    // Control bundle: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[1:0]}
    localparam int CTRL_W          = 8;
    localparam int CTRL_REG_WRITE  = 7;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_ALU_SRC    = 3;
    localparam int CTRL_REG_DST    = 2;
    localparam int CTRL_ALU_OP_LO  = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // The forwarding unit encodes A and B differently: the EX/MEM and
    // MEM/WB codes are swapped between the two operands. 2'b11 and 2'b00
    // both fall through to the register-file value.
    localparam logic [1:0] FWD_A_EXMEM = 2'b10;
    localparam logic [1:0] FWD_A_MEMWB = 2'b01;
    localparam logic [1:0] FWD_B_EXMEM = 2'b01;
    localparam logic [1:0] FWD_B_MEMWB = 2'b10;

    // Destination register: rd for R-type (RegDst=1), rt otherwise.
    function automatic logic [4:0] dest_reg(input logic [CTRL_W-1:0] ctrl,
                                            input logic [4:0]        rt,
                                            input logic [4:0]        rd);
        return ctrl[CTRL_REG_DST] ? rd : rt;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
//   Bundles the ID-side inputs, forwarding controls/sources and the EX-side
//   outputs of the ID/EX stage.
//   master : the surrounding pipeline (drives Id*, Flush, Forward*, sources)
//   slave  : id_ex_stage (drives IdEx*, AluOp*, StoreData, Stall, counters)
// -----------------------------------------------------------------------------
interface id_ex_stage_if
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // ID side
    logic              IdValid;
    logic [4:0]        IdRegRs;
    logic [4:0]        IdRegRt;
    logic [4:0]        IdRegRd;
    logic [DATA_W-1:0] IdReadData1;
    logic [DATA_W-1:0] IdReadData2;
    logic [DATA_W-1:0] IdImm;
    logic [CTRL_W-1:0] IdCtrl;
    logic              Flush;
    // forwarding
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic [DATA_W-1:0] ExMemAluResult;
    logic [DATA_W-1:0] MemWbWriteData;
    // EX side
    logic              IdExValid;
    logic [4:0]        IdExRegRs;
    logic [4:0]        IdExRegRt;
    logic [4:0]        IdExWriteReg;
    logic [CTRL_W-1:0] IdExCtrl;
    logic [DATA_W-1:0] AluOpA;
    logic [DATA_W-1:0] AluOpB;
    logic [DATA_W-1:0] StoreData;
    logic              Stall;
    logic [CNT_W-1:0]  StallCount;
    logic [CNT_W-1:0]  FlushCount;

    modport master (
        output IdValid, IdRegRs, IdRegRt, IdRegRd, IdReadData1, IdReadData2,
               IdImm, IdCtrl, Flush, ForwardA, ForwardB, ExMemAluResult,
               MemWbWriteData,
        input  IdExValid, IdExRegRs, IdExRegRt, IdExWriteReg, IdExCtrl,
               AluOpA, AluOpB, StoreData, Stall, StallCount, FlushCount
    );

    modport slave (
        input  IdValid, IdRegRs, IdRegRt, IdRegRd, IdReadData1, IdReadData2,
               IdImm, IdCtrl, Flush, ForwardA, ForwardB, ExMemAluResult,
               MemWbWriteData,
        output IdExValid, IdExRegRs, IdExRegRt, IdExWriteReg, IdExCtrl,
               AluOpA, AluOpB, StoreData, Stall, StallCount, FlushCount
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux3.sv
// -----------------------------------------------------------------------------
// fwd_mux3
//   3:1 forwarding operand mux. The select codes for the EX/MEM and MEM/WB
//   sources are parameters so one module serves both operands; any other
//   code returns the register-file value.
//   sel        in  2  forwarding select
//   reg_val    in  W  registered register-file operand
//   exmem_val  in  W  EX/MEM forward source
//   memwb_val  in  W  MEM/WB forward source
//   out        out W  selected operand
// -----------------------------------------------------------------------------
module fwd_mux3 #(
    parameter int         W         = 32,
    parameter logic [1:0] EXMEM_SEL = 2'b10,
    parameter logic [1:0] MEMWB_SEL = 2'b01
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] reg_val,
    input  logic [W-1:0] exmem_val,
    input  logic [W-1:0] memwb_val,
    output logic [W-1:0] out
);
    always_comb begin
        out = reg_val;
        if (sel == EXMEM_SEL)
            out = exmem_val;
        else if (sel == MEMWB_SEL)
            out = memwb_val;
    end
endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register plus EX-stage operand selection.
//   Captures the decoded instruction every cycle, inserts a bubble on Flush
//   or on a load-use hazard (Stall), forwards ALU operands combinationally,
//   and keeps saturating counts of flush and stall bubbles.
//   clk    in  rising-edge clock
//   rst_n  in  synchronous active-low reset
//   bus    id_ex_stage_if.slave: ID inputs, forwarding, EX outputs, counters
// -----------------------------------------------------------------------------
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        wreg;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
    } ex_fields_t;

    ex_fields_t        ex_q, ex_d;
    logic              stall;
    logic [DATA_W-1:0] fwd_b;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    // Load-use: the load in EX writes a register the instruction in ID reads.
    // A flush kills the ID instruction anyway, so it never stalls.
    always_comb begin
        stall = ex_q.valid & ex_q.ctrl[CTRL_MEM_READ] & (ex_q.wreg != 5'd0)
              & ((ex_q.wreg == bus.IdRegRs) | (ex_q.wreg == bus.IdRegRt))
              & bus.IdValid & ~bus.Flush;
    end

    // Next EX contents: an all-zero bubble unless the ID instruction advances.
    always_comb begin
        ex_d = '0;
        if (!bus.Flush && !stall) begin
            ex_d.valid = bus.IdValid;
            ex_d.rs    = bus.IdRegRs;
            ex_d.rt    = bus.IdRegRt;
            ex_d.wreg  = dest_reg(bus.IdCtrl, bus.IdRegRt, bus.IdRegRd);
            ex_d.ctrl  = bus.IdCtrl;
            ex_d.rd1   = bus.IdReadData1;
            ex_d.rd2   = bus.IdReadData2;
            ex_d.imm   = bus.IdImm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            ex_q <= ex_d;
            // Flush wins over a simultaneous hazard; counters hold at all-ones.
            if (bus.Flush) begin
                if (!(&flush_cnt)) flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (stall) begin
                if (!(&stall_cnt)) stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    fwd_mux3 #(.W(DATA_W), .EXMEM_SEL(FWD_A_EXMEM), .MEMWB_SEL(FWD_A_MEMWB)) u_fwd_a (
        .sel       (bus.ForwardA),
        .reg_val   (ex_q.rd1),
        .exmem_val (bus.ExMemAluResult),
        .memwb_val (bus.MemWbWriteData),
        .out       (bus.AluOpA)
    );

    fwd_mux3 #(.W(DATA_W), .EXMEM_SEL(FWD_B_EXMEM), .MEMWB_SEL(FWD_B_MEMWB)) u_fwd_b (
        .sel       (bus.ForwardB),
        .reg_val   (ex_q.rd2),
        .exmem_val (bus.ExMemAluResult),
        .memwb_val (bus.MemWbWriteData),
        .out       (fwd_b)
    );

    // Store data is the forwarded rt value, before the immediate select.
    assign bus.StoreData    = fwd_b;
    assign bus.AluOpB       = ex_q.ctrl[CTRL_ALU_SRC] ? ex_q.imm : fwd_b;
    assign bus.IdExValid    = ex_q.valid;
    assign bus.IdExRegRs    = ex_q.rs;
    assign bus.IdExRegRt    = ex_q.rt;
    assign bus.IdExWriteReg = ex_q.wreg;
    assign bus.IdExCtrl     = ex_q.ctrl;
    assign bus.Stall        = stall;
    assign bus.StallCount   = stall_cnt;
    assign bus.FlushCount   = flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Table-driven check of capture and forwarding, followed by hand-written
//   sequences for load-use stall, $0 destination, flush-over-stall, reset
//   mid-stall and counter saturation. A second instance with a 3-bit counter
//   shares all inputs so saturation is reachable in a few cycles.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(32), .CNT_W(16)) bus ();
    id_ex_stage_if #(.DATA_W(32), .CNT_W(3))  sbus ();

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut     (.clk(clk), .rst_n(rst_n), .bus(bus));
    id_ex_stage #(.DATA_W(32), .CNT_W(3))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));

    assign sbus.IdValid        = bus.IdValid;
    assign sbus.IdRegRs        = bus.IdRegRs;
    assign sbus.IdRegRt        = bus.IdRegRt;
    assign sbus.IdRegRd        = bus.IdRegRd;
    assign sbus.IdReadData1    = bus.IdReadData1;
    assign sbus.IdReadData2    = bus.IdReadData2;
    assign sbus.IdImm          = bus.IdImm;
    assign sbus.IdCtrl         = bus.IdCtrl;
    assign sbus.Flush          = bus.Flush;
    assign sbus.ForwardA       = bus.ForwardA;
    assign sbus.ForwardB       = bus.ForwardB;
    assign sbus.ExMemAluResult = bus.ExMemAluResult;
    assign sbus.MemWbWriteData = bus.MemWbWriteData;

    localparam logic [7:0] C_RTYPE = 8'h86; // RegWrite, RegDst, ALUOp=10
    localparam logic [7:0] C_ADDI  = 8'h88; // RegWrite, ALUSrc
    localparam logic [7:0] C_LW    = 8'hD8; // RegWrite, MemRead, MemToReg, ALUSrc
    localparam logic [7:0] C_SW    = 8'h28; // MemWrite, ALUSrc

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, imm;
        logic [7:0]  c;
        logic [1:0]  fa, fb;
        logic [31:0] em, mw;
        logic [4:0]  e_wreg;
        logic [31:0] e_a, e_b, e_st;
        logic        e_stall;
    } vec_t;

    function automatic vec_t mkv(input logic v, input logic [4:0] rs, rt, rd,
                                 input logic [31:0] d1, d2, imm, input logic [7:0] c,
                                 input logic [1:0] fa, fb, input logic [31:0] em, mw,
                                 input logic [4:0] ew, input logic [31:0] ea, eb, es,
                                 input logic est);
        vec_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.rd = rd; r.d1 = d1; r.d2 = d2; r.imm = imm;
        r.c = c; r.fa = fa; r.fb = fb; r.em = em; r.mw = mw;
        r.e_wreg = ew; r.e_a = ea; r.e_b = eb; r.e_st = es; r.e_stall = est;
        return r;
    endfunction

    task automatic set_id(input logic v, input logic [4:0] rs, rt, rd,
                          input logic [31:0] d1, d2, imm, input logic [7:0] c);
        bus.IdValid = v; bus.IdRegRs = rs; bus.IdRegRt = rt; bus.IdRegRd = rd;
        bus.IdReadData1 = d1; bus.IdReadData2 = d2; bus.IdImm = imm; bus.IdCtrl = c;
    endtask

    task automatic set_fwd(input logic [1:0] fa, fb, input logic [31:0] em, mw);
        bus.ForwardA = fa; bus.ForwardB = fb; bus.ExMemAluResult = em; bus.MemWbWriteData = mw;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.Flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 8'd0);
        set_fwd(2'b00, 2'b00, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // lw $4 in EX, then sub $5,$6,$4 presented in ID
    task automatic load_then_use(input logic [4:0] lw_rt, input logic [4:0] use_rt);
        set_id(1'b1, 5'd1, lw_rt, 5'd0, 32'h300, 32'd0, 32'd0, C_LW);
        @(posedge clk); #1;
        set_id(1'b1, 5'd6, use_rt, 5'd5, 32'h60, 32'h40, 32'd0, C_RTYPE);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = mkv(1, 1, 2, 3, 32'h11, 32'h22, 32'h1820, C_RTYPE, 2'b10, 2'b10,
                      32'h55, 32'h77, 3, 32'h55, 32'h77, 32'h77, 0);
        vecs[1] = mkv(1, 5, 6, 7, 32'h100, 32'h200, 32'h0, C_RTYPE, 2'b00, 2'b00,
                      32'hEEEE, 32'hFFFF, 7, 32'h100, 32'h200, 32'h200, 0);
        vecs[2] = mkv(1, 8, 9, 10, 32'h10, 32'h20, 32'h0, C_RTYPE, 2'b01, 2'b01,
                      32'hAAAA, 32'hBBBB, 10, 32'hBBBB, 32'hAAAA, 32'hAAAA, 0);
        vecs[3] = mkv(1, 13, 14, 15, 32'h1234, 32'h5678, 32'h0, C_RTYPE, 2'b11, 2'b11,
                      32'hAAAA, 32'hBBBB, 15, 32'h1234, 32'h5678, 32'h5678, 0);
        vecs[4] = mkv(1, 8, 9, 31, 32'h40, 32'h999, 32'hFFFF_FFFC, C_ADDI, 2'b00, 2'b01,
                      32'hCAFE, 32'h1, 9, 32'h40, 32'hFFFF_FFFC, 32'hCAFE, 0);
        vecs[5] = mkv(1, 11, 10, 0, 32'h2000, 32'hDEAD, 32'h8, C_SW, 2'b00, 2'b10,
                      32'h5, 32'hBEEF, 10, 32'h2000, 32'h8, 32'hBEEF, 0);
        vecs[6] = mkv(0, 2, 3, 12, 32'h1, 32'h2, 32'h3, C_RTYPE, 2'b00, 2'b00,
                      32'h0, 32'h0, 12, 32'h1, 32'h2, 32'h2, 0);
        // lw $4,16($1) in EX while the same lw sits in ID: it reads rt=$4
        vecs[7] = mkv(1, 1, 4, 0, 32'h300, 32'h44, 32'h10, C_LW, 2'b00, 2'b00,
                      32'h0, 32'h0, 4, 32'h300, 32'h10, 32'h44, 1);

        // 1. reset
        do_reset();
        chk("rst_valid", {31'd0, bus.IdExValid}, 32'd0);
        chk("rst_ctrl", {24'd0, bus.IdExCtrl}, 32'd0);
        chk("rst_stall", {31'd0, bus.Stall}, 32'd0);
        chk("rst_stallcnt", {16'd0, bus.StallCount}, 32'd0);
        chk("rst_flushcnt", {16'd0, bus.FlushCount}, 32'd0);

        // 2. table: capture, destination select, forwarding, ALUSrc
        for (int i = 0; i < 8; i++) begin
            set_id(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                   vecs[i].d1, vecs[i].d2, vecs[i].imm, vecs[i].c);
            set_fwd(vecs[i].fa, vecs[i].fb, vecs[i].em, vecs[i].mw);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), {31'd0, bus.IdExValid}, {31'd0, vecs[i].v});
            chk($sformatf("v%0d_wreg", i), {27'd0, bus.IdExWriteReg}, {27'd0, vecs[i].e_wreg});
            chk($sformatf("v%0d_ctrl", i), {24'd0, bus.IdExCtrl}, {24'd0, vecs[i].c});
            chk($sformatf("v%0d_rs", i), {27'd0, bus.IdExRegRs}, {27'd0, vecs[i].rs});
            chk($sformatf("v%0d_alua", i), bus.AluOpA, vecs[i].e_a);
            chk($sformatf("v%0d_alub", i), bus.AluOpB, vecs[i].e_b);
            chk($sformatf("v%0d_store", i), bus.StoreData, vecs[i].e_st);
            chk($sformatf("v%0d_stall", i), {31'd0, bus.Stall}, {31'd0, vecs[i].e_stall});
        end

        // 3. load-use stall: one bubble, then the dependent instruction enters
        do_reset();
        load_then_use(5'd4, 5'd4);
        chk("lu_stall", {31'd0, bus.Stall}, 32'd1);
        @(posedge clk); #1;
        chk("lu_bubble_valid", {31'd0, bus.IdExValid}, 32'd0);
        chk("lu_bubble_ctrl", {24'd0, bus.IdExCtrl}, 32'd0);
        chk("lu_stallcnt", {16'd0, bus.StallCount}, 32'd1);
        chk("lu_stall_drop", {31'd0, bus.Stall}, 32'd0);
        @(posedge clk); #1;
        chk("lu_sub_valid", {31'd0, bus.IdExValid}, 32'd1);
        chk("lu_sub_wreg", {27'd0, bus.IdExWriteReg}, 32'd5);
        chk("lu_sub_ctrl", {24'd0, bus.IdExCtrl}, {24'd0, C_RTYPE});
        chk("lu_stallcnt_hold", {16'd0, bus.StallCount}, 32'd1);

        // 4. load to $0 never stalls
        load_then_use(5'd0, 5'd0);
        chk("zero_stall", {31'd0, bus.Stall}, 32'd0);
        @(posedge clk); #1;
        chk("zero_valid", {31'd0, bus.IdExValid}, 32'd1);
        chk("zero_wreg", {27'd0, bus.IdExWriteReg}, 32'd5);
        chk("zero_stallcnt", {16'd0, bus.StallCount}, 32'd1);

        // 5. flush while hazard holds: counted as flush only
        load_then_use(5'd4, 5'd4);
        bus.Flush = 1'b1;
        #1;
        chk("fl_stall", {31'd0, bus.Stall}, 32'd0);
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        chk("fl_valid", {31'd0, bus.IdExValid}, 32'd0);
        chk("fl_ctrl", {24'd0, bus.IdExCtrl}, 32'd0);
        chk("fl_flushcnt", {16'd0, bus.FlushCount}, 32'd1);
        chk("fl_stallcnt", {16'd0, bus.StallCount}, 32'd1);

        // reset in the middle of a stall discards everything
        load_then_use(5'd4, 5'd4);
        chk("rs_stall", {31'd0, bus.Stall}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rs_valid", {31'd0, bus.IdExValid}, 32'd0);
        chk("rs_stallcnt", {16'd0, bus.StallCount}, 32'd0);
        chk("rs_flushcnt", {16'd0, bus.FlushCount}, 32'd0);

        // 6. saturation: 3-bit counter stops at 7, 16-bit one keeps counting
        for (int i = 1; i <= 9; i++) begin
            load_then_use(5'd4, 5'd4);
            @(posedge clk); #1;
            if (i == 7) chk("sat_at7", {29'd0, sbus.StallCount}, 32'd7);
        end
        chk("sat_hold", {29'd0, sbus.StallCount}, 32'd7);
        chk("nosat_cnt", {16'd0, bus.StallCount}, 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
